lj_force_accumulator: RTL and testbench
=======================================

// Module: lj_force_accumulator
// PURPOSE
//  Consumer end of the pairwise LJ datapath. Takes the per-pair fp32 velocity-delta vectors
//  (force*DT, {z,y,x}, 32b each) for one reference particle over a valid/ready stream.
//  Sums them per component. Presents the total once per reference particle, with a
//  valid/ready handshake, to the downstream velocity/position update stage.
//  Sits directly after the LJ pair units in the force pipeline.
// PARAMETERS
//  ID_W     8            width of the reference-particle index carried alongside the sum
//  MAX_CNT  16'hFFFF     beat-count saturation value for the pair counter
// PORTS
//  clk        in   1       single system clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       lj_in/in_id/in_last valid this cycle
//  in_ready   out  1       accumulator can take a beat this cycle
//  lj_in      in   96      fp32 delta vector {z[95:64],y[63:32],x[31:0]}
//  in_id      in   ID_W    reference-particle index; sampled on first beat of a group
//  in_last    in   1       final beat of the current reference particle's group
//  out_valid  out  1       sum_out/out_id/out_cnt valid
//  out_ready  in   1       downstream accepts the result
//  sum_out    out  96      per-component fp32 sum of the group
//  out_id     out  ID_W    index latched from the group's first beat
//  out_cnt    out  16      number of beats in the group, saturating at MAX_CNT
//  vel_in     in   96      current velocity (used only with VEL_UPDATE_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=ACC, acc=96'h0, first=1, cnt=0, out_valid=0,
//    sum_out=0, out_id=0, out_cnt=0. in_ready=1 once reset is released.
//    Reset mid-group discards the partial sum. No output is produced for it.
//  Adders: three combinational fp32_add units compute acc+lj_in, one per component.
//    Result is registered on accept. Add 0x00000000 to 0x80000000 -> 0x00000000.
//  Beat accept: in_valid & in_ready. Do not gate in_ready combinationally on in_valid.
//  FSM states:
//   ACC: in_ready=1, out_valid=0.
//     On accept with first=1: latch in_id, set first=0.
//     On accept: acc<=acc+lj_in; cnt<=min(cnt+1,MAX_CNT).
//     On accept with in_last=1: go to HOLD.
//       sum_out<=acc+lj_in; out_id<=latched id (or in_id if first beat); out_cnt<=cnt+1 (sat).
//       Clear acc=0, cnt=0, first=1.
//   HOLD: out_valid=1, in_ready=0. sum_out/out_id/out_cnt hold stable until out_ready=1.
//     On out_ready=1: return to ACC next cycle. No beat is accepted in the handoff cycle.
//  Latency: last beat accepted at cycle N -> out_valid=1 at cycle N+1. Min group period 2 cycles.
//  Single-beat group (first & last on the same beat): sum_out=lj_in, out_cnt=1.
//  Counter saturation: cnt stops at MAX_CNT. The sum keeps accumulating.
//  in_valid with lj_in=0 (the r2==0 self-pair case) is still counted and accumulated.
//  No NaN/Inf special handling beyond what fp32_add produces.
// CONFIGURATION
//  VEL_UPDATE_EN defined: the HOLD-entry adder input adds vel_in.
//    sum_out = vel_in + acc + lj_in, i.e. the new velocity.
//    vel_in is sampled on the last beat, via one extra fp32_add per component (chained).
//  VEL_UPDATE_EN undefined: vel_in is unused and sum_out is the raw delta sum.
//    Latency is identical in both builds.
// TESTING
//  1 Reset: assert rst_n=0 mid-run with in_valid=1.
//    -> out_valid=0, sum_out=0 immediately (async).
//    -> in_ready=1 the first cycle after release.
//  2 Three beats of x=0x3f800000 (1.0), last on beat 3, id=5.
//    -> next cycle out_valid=1, sum_out.x=0x40400000 (3.0), y=z=0, out_id=5, out_cnt=3.
//  3 Backpressure: hold out_ready=0 for 4 cycles after case 2.
//    -> in_ready=0, outputs stable.
//    -> out_ready=1 then ACC; the next group starts with acc=0.
//  4 Single beat {z=0xbf800000,y=0x3f000000,x=0x40000000}, in_last=1, id=9.
//    -> sum_out = that vector, out_cnt=1, out_id=9.
//  5 Cancellation: beats x=0x40000000 then x=0xc0000000 (last).
//    -> sum_out.x=0x00000000.
//    -> in_id changed on beat 2 is ignored; out_id is from beat 1.
//  6 VEL_UPDATE_EN build: vel_in.x=0x3f800000 with case 2 stimulus.
//    -> sum_out.x=0x40800000 (4.0).
//    Without the macro, vel_in toggling has no effect on any output.

Source files
------------

// File: rtl/lj_force_accumulator.sv
// rtl/lj_force_accumulator.sv - per-reference-particle fp32 vector accumulator for the LJ force pipeline
//
// fp32_add
//   Combinational IEEE-754 single-precision adder, round-to-nearest-even,
//   gradual underflow, overflow to infinity, NaN on NaN input or inf-inf.
//   i_a, i_b : operands
//   o_sum    : i_a + i_b
//
// lj_force_accumulator
//   Sums the per-pair velocity-delta vectors {z,y,x} of one reference particle
//   and presents the per-component total, the particle index and the beat count
//   once per group over a valid/ready handshake.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : input beat handshake (in_ready depends on state only)
//   lj_in              : fp32 delta vector {z[95:64], y[63:32], x[31:0]}
//   in_id              : reference-particle index, taken from the first beat
//   in_last            : final beat of the group
//   out_valid/out_ready: result handshake
//   sum_out            : per-component fp32 sum of the group
//   out_id             : index latched from the group's first beat
//   out_cnt            : beats in the group, saturating at MAX_CNT
//   vel_in             : current velocity, added to the result only with VEL_UPDATE_EN
//
// Build option: define VEL_UPDATE_EN to make sum_out = vel_in + group sum.

module fp32_add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);

  logic        a_s, b_s, a_nan, b_nan, a_inf, b_inf, swap;
  logic [7:0]  a_e, b_e;
  logic [22:0] a_f, b_f;
  logic        big_s, small_s;
  logic [7:0]  big_e, small_e, big_ee, small_ee, d;
  logic [22:0] big_f, small_f;
  logic [26:0] big_x, small_x, small_sh, norm;
  logic        sticky, round_up;
  logic [27:0] raw;
  logic [4:0]  lz;
  logic [9:0]  e_work, shift, e_field;
  logic [24:0] rounded;
  logic [22:0] mant;

  assign a_s = i_a[31];
  assign a_e = i_a[30:23];
  assign a_f = i_a[22:0];
  assign b_s = i_b[31];
  assign b_e = i_b[30:23];
  assign b_f = i_b[22:0];

  always_comb begin
    o_sum    = 32'h0;
    a_nan    = (a_e == 8'hFF) && (a_f != 23'h0);
    b_nan    = (b_e == 8'hFF) && (b_f != 23'h0);
    a_inf    = (a_e == 8'hFF) && (a_f == 23'h0);
    b_inf    = (b_e == 8'hFF) && (b_f == 23'h0);
    swap     = 1'b0;
    big_s    = 1'b0;
    small_s  = 1'b0;
    big_e    = 8'h0;
    small_e  = 8'h0;
    big_f    = 23'h0;
    small_f  = 23'h0;
    big_ee   = 8'h0;
    small_ee = 8'h0;
    d        = 8'h0;
    big_x    = 27'h0;
    small_x  = 27'h0;
    small_sh = 27'h0;
    sticky   = 1'b0;
    raw      = 28'h0;
    lz       = 5'd27;
    e_work   = 10'h0;
    shift    = 10'h0;
    norm     = 27'h0;
    e_field  = 10'h0;
    round_up = 1'b0;
    rounded  = 25'h0;
    mant     = 23'h0;

    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
      o_sum = 32'h7FC00000;
    end else if (a_inf) begin
      o_sum = i_a;
    end else if (b_inf) begin
      o_sum = i_b;
    end else begin
      // Order by magnitude so the subtraction below never goes negative.
      swap    = {b_e, b_f} > {a_e, a_f};
      big_s   = swap ? b_s : a_s;
      big_e   = swap ? b_e : a_e;
      big_f   = swap ? b_f : a_f;
      small_s = swap ? a_s : b_s;
      small_e = swap ? a_e : b_e;
      small_f = swap ? a_f : b_f;

      // Denormals share the exponent of the smallest normal, without the hidden bit.
      big_ee   = (big_e == 8'h0) ? 8'd1 : big_e;
      small_ee = (small_e == 8'h0) ? 8'd1 : small_e;
      d        = big_ee - small_ee;
      big_x    = {(big_e != 8'h0), big_f, 3'b000};
      small_x  = {(small_e != 8'h0), small_f, 3'b000};

      // Three extra LSBs carry guard, round and a sticky OR of everything shifted out.
      if (d >= 8'd27) begin
        small_sh = 27'h0;
        sticky   = |small_x;
      end else begin
        small_sh = small_x >> d;
        sticky   = |(small_x & ((27'h1 << d) - 27'h1));
      end
      small_sh[0] = small_sh[0] | sticky;

      if (big_s == small_s) begin
        raw = {1'b0, big_x} + {1'b0, small_sh};
      end else begin
        raw = {1'b0, big_x} - {1'b0, small_sh};
      end

      if (raw == 28'h0) begin
        // Exact cancellation yields +0; only -0 + -0 keeps the negative sign.
        o_sum = {big_s & small_s, 31'h0};
      end else begin
        e_work = {2'b00, big_ee};
        if (raw[27]) begin
          norm   = {raw[27:2], raw[1] | raw[0]};
          e_work = e_work + 10'd1;
        end else begin
          for (int i = 0; i <= 26; i++) begin
            if (raw[i]) lz = 5'(26 - i);
          end
          // Stop normalising at the denormal boundary.
          if ({5'b0, lz} < e_work) shift = {5'b0, lz};
          else                     shift = e_work - 10'd1;
          norm   = raw[26:0] << shift;
          e_work = e_work - shift;
        end

        e_field  = norm[26] ? e_work : 10'd0;
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded  = {1'b0, norm[26:3]} + {24'h0, round_up};
        if (rounded[24]) begin
          mant    = rounded[23:1];
          e_field = e_field + 10'd1;
        end else begin
          mant = rounded[22:0];
          // A denormal that rounds up into the hidden bit becomes the smallest normal.
          if ((e_field == 10'd0) && rounded[23]) e_field = 10'd1;
        end

        if (e_field >= 10'd255) o_sum = {big_s, 8'hFF, 23'h0};
        else                    o_sum = {big_s, e_field[7:0], mant};
      end
    end
  end

endmodule

module lj_force_accumulator #(
  parameter int          ID_W    = 8,
  parameter logic [15:0] MAX_CNT = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [95:0]     lj_in,
  input  logic [ID_W-1:0] in_id,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [95:0]     sum_out,
  output logic [ID_W-1:0] out_id,
  output logic [15:0]     out_cnt,
  input  logic [95:0]     vel_in
);

  typedef enum logic {S_ACC, S_HOLD} state_t;

  state_t          r_state, w_next_state;
  logic [95:0]     r_acc, r_sum;
  logic            r_first;
  logic [15:0]     r_cnt, r_out_cnt;
  logic [ID_W-1:0] r_id, r_out_id;

  logic [95:0]     w_new, w_final;
  logic [15:0]     w_cnt_inc;
  logic            w_accept;

  // One adder per component: running sum plus the incoming delta.
  for (genvar g = 0; g < 3; g++) begin : g_acc_add
    fp32_add u_add (
      .i_a   (r_acc[32*g +: 32]),
      .i_b   (lj_in[32*g +: 32]),
      .o_sum (w_new[32*g +: 32])
    );
  end

`ifdef VEL_UPDATE_EN
  // Chained after the accumulate adder so the group result becomes the new velocity.
  for (genvar g = 0; g < 3; g++) begin : g_vel_add
    fp32_add u_vadd (
      .i_a   (vel_in[32*g +: 32]),
      .i_b   (w_new[32*g +: 32]),
      .o_sum (w_final[32*g +: 32])
    );
  end
`else
  logic w_unused_vel;
  assign w_unused_vel = ^vel_in;
  assign w_final      = w_new;
`endif

  assign w_cnt_inc = (r_cnt >= MAX_CNT) ? MAX_CNT : (r_cnt + 16'd1);
  assign w_accept  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ACC;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_next_state = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        // The handoff cycle takes no beat because in_ready stays low here.
        if (out_ready) w_next_state = S_ACC;
      end
      default: w_next_state = S_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= 96'h0;
      r_first   <= 1'b1;
      r_cnt     <= 16'h0;
      r_id      <= '0;
      r_sum     <= 96'h0;
      r_out_id  <= '0;
      r_out_cnt <= 16'h0;
    end else if (w_accept) begin
      if (in_last) begin
        r_sum     <= w_final;
        r_out_id  <= r_first ? in_id : r_id;
        r_out_cnt <= w_cnt_inc;
        r_acc     <= 96'h0;
        r_cnt     <= 16'h0;
        r_first   <= 1'b1;
      end else begin
        r_acc <= w_new;
        r_cnt <= w_cnt_inc;
        if (r_first) begin
          r_id    <= in_id;
          r_first <= 1'b0;
        end
      end
    end
  end

  assign sum_out = r_sum;
  assign out_id  = r_out_id;
  assign out_cnt = r_out_cnt;

endmodule

// File: tb/tb_lj_force_accumulator.sv
// tb/tb_lj_force_accumulator.sv - directed self-checking bench for lj_force_accumulator

module tb_lj_force_accumulator;

  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] TWO   = 32'h40000000;
  localparam logic [31:0] THREE = 32'h40400000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] lj_in;
  logic [7:0]  in_id;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] sum_out;
  logic [7:0]  out_id;
  logic [15:0] out_cnt;
  logic [95:0] vel_in;

  int errors = 0;
  int checks = 0;

  lj_force_accumulator #(.ID_W(8), .MAX_CNT(16'd5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lj_in     (lj_in),
    .in_id     (in_id),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .out_id    (out_id),
    .out_cnt   (out_cnt),
    .vel_in    (vel_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_beat(input logic [95:0] v, input logic [7:0] id, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    lj_in    = v;
    in_id    = id;
    in_last  = last;
  endtask

  task automatic end_group();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; lj_in = 96'h0; in_id = 8'h0; in_last = 1'b0;
    out_ready = 1'b1; vel_in = 96'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum_out !== 96'h0) begin errors++; $display("FAIL reset_sum_out: got %h expected 0", sum_out); end
    checks++; if (out_cnt !== 16'h0) begin errors++; $display("FAIL reset_out_cnt: got %h expected 0", out_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_three_beats();
    logic [95:0] exp_sum;
`ifdef VEL_UPDATE_EN
    exp_sum = {32'h0, 32'h0, 32'h40800000};
`else
    exp_sum = {32'h0, 32'h0, THREE};
`endif
    out_ready = 1'b0;
    vel_in    = {32'h0, 32'h0, ONE};
    drive_beat({32'h0, 32'h0, ONE}, 8'd5, 1'b0);
    drive_beat({32'h0, 32'h0, ONE}, 8'd5, 1'b0);
    drive_beat({32'h0, 32'h0, ONE}, 8'd5, 1'b1);
    end_group();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL three_out_valid: got %b expected 1", out_valid); end
    checks++; if (sum_out !== exp_sum) begin errors++; $display("FAIL three_sum: got %h expected %h", sum_out, exp_sum); end
    checks++; if (out_id !== 8'd5) begin errors++; $display("FAIL three_id: got %0d expected 5", out_id); end
    checks++; if (out_cnt !== 16'd3) begin errors++; $display("FAIL three_cnt: got %0d expected 3", out_cnt); end
  endtask

  task automatic test_backpressure();
    logic [95:0] exp_sum;
`ifdef VEL_UPDATE_EN
    exp_sum = {32'h0, 32'h0, 32'h40800000};
`else
    exp_sum = {32'h0, 32'h0, THREE};
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_last = 1'b1; in_id = 8'hEE;
      lj_in    = {ONE, ONE, ONE};
      vel_in   = {$urandom, $urandom, $urandom};
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", c, out_valid); end
      checks++; if (sum_out !== exp_sum) begin errors++; $display("FAIL bp_sum[%0d]: got %h expected %h", c, sum_out, exp_sum); end
      checks++; if ({out_id, out_cnt} !== {8'd5, 16'd3}) begin errors++; $display("FAIL bp_id_cnt[%0d]: got %h expected 050003", c, {out_id, out_cnt}); end
    end
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0; vel_in = 96'h0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    drive_beat({32'h0, 32'h0, ONE}, 8'd7, 1'b1);
    end_group();
    checks++; if (sum_out !== {32'h0, 32'h0, ONE}) begin errors++; $display("FAIL bp_next_sum: got %h expected %h", sum_out, {32'h0, 32'h0, ONE}); end
    checks++; if ({out_id, out_cnt} !== {8'd7, 16'd1}) begin errors++; $display("FAIL bp_next_id_cnt: got %h expected 070001", {out_id, out_cnt}); end
  endtask

  task automatic test_single_beat();
    logic [95:0] v;
    v = {32'hBF800000, 32'h3F000000, 32'h40000000};
    drive_beat(v, 8'd9, 1'b1);
    end_group();
    checks++; if (sum_out !== v) begin errors++; $display("FAIL single_sum: got %h expected %h", sum_out, v); end
    checks++; if (out_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", out_cnt); end
    checks++; if (out_id !== 8'd9) begin errors++; $display("FAIL single_id: got %0d expected 9", out_id); end
  endtask

  task automatic test_mixed();
    logic [95:0] exp_sum;
    exp_sum = {32'h00000000, TWO, 32'h3FE00000};
    drive_beat({32'h80000000, THREE, ONE}, 8'd3, 1'b0);
    drive_beat({32'h80000000, 32'hBF800000, 32'h3F000000}, 8'd3, 1'b0);
    drive_beat(96'h0, 8'd3, 1'b0);
    drive_beat({32'h80000000, 32'h0, 32'h3E800000}, 8'd3, 1'b1);
    end_group();
    checks++; if (sum_out !== exp_sum) begin errors++; $display("FAIL mixed_sum: got %h expected %h", sum_out, exp_sum); end
    checks++; if (out_cnt !== 16'd4) begin errors++; $display("FAIL mixed_cnt: got %0d expected 4", out_cnt); end
  endtask

  task automatic test_cancellation();
    drive_beat({32'h0, 32'h0, TWO}, 8'd4, 1'b0);
    drive_beat({32'h0, 32'h0, 32'hC0000000}, 8'd8, 1'b1);
    end_group();
    checks++; if (sum_out !== 96'h0) begin errors++; $display("FAIL cancel_sum: got %h expected 0", sum_out); end
    checks++; if (out_id !== 8'd4) begin errors++; $display("FAIL cancel_id: got %0d expected 4", out_id); end
    checks++; if (out_cnt !== 16'd2) begin errors++; $display("FAIL cancel_cnt: got %0d expected 2", out_cnt); end
  endtask

  task automatic test_back_to_back();
    drive_beat({32'h0, 32'h0, ONE}, 8'd1, 1'b1);
    drive_beat({32'h0, 32'h0, TWO}, 8'd2, 1'b1);
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL b2b_handoff: got %b expected 10", {out_valid, in_ready}); end
    checks++; if ({out_id, sum_out[31:0]} !== {8'd1, ONE}) begin errors++; $display("FAIL b2b_first: got %h expected %h", {out_id, sum_out[31:0]}, {8'd1, ONE}); end
    @(negedge clk); #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL b2b_acc: got %b expected 01", {out_valid, in_ready}); end
    end_group();
    checks++; if (sum_out !== {32'h0, 32'h0, TWO}) begin errors++; $display("FAIL b2b_second_sum: got %h expected %h", sum_out, {32'h0, 32'h0, TWO}); end
    checks++; if ({out_id, out_cnt} !== {8'd2, 16'd1}) begin errors++; $display("FAIL b2b_second_id_cnt: got %h expected 020001", {out_id, out_cnt}); end
  endtask

  task automatic test_saturation();
    for (int b = 0; b < 7; b++) drive_beat({32'h0, 32'h0, ONE}, 8'd6, (b == 6));
    end_group();
    checks++; if (out_cnt !== 16'd5) begin errors++; $display("FAIL sat_cnt: got %0d expected 5", out_cnt); end
    checks++; if (sum_out !== {32'h0, 32'h0, 32'h40E00000}) begin errors++; $display("FAIL sat_sum: got %h expected %h", sum_out, {32'h0, 32'h0, 32'h40E00000}); end
  endtask

  task automatic test_reset_mid();
    drive_beat({32'h0, 32'h0, ONE}, 8'd1, 1'b0);
    drive_beat({32'h0, 32'h0, ONE}, 8'd1, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b0;
    drive_beat({32'h0, 32'h0, TWO}, 8'd2, 1'b1);
    end_group();
    checks++; if (sum_out !== {32'h0, 32'h0, TWO}) begin errors++; $display("FAIL midrst_discard: got %h expected %h", sum_out, {32'h0, 32'h0, TWO}); end
    checks++; if ({out_valid, out_cnt} !== {1'b1, 16'd1}) begin errors++; $display("FAIL midrst_cnt: got %h expected 10001", {out_valid, out_cnt}); end
    #2; rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_rst_valid: got %b expected 0", out_valid); end
    checks++; if ({sum_out, out_id, out_cnt} !== 120'h0) begin errors++; $display("FAIL hold_rst_outputs: got %h expected 0", {sum_out, out_id, out_cnt}); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_three_beats();
    test_backpressure();
    test_single_beat();
    test_mixed();
    test_cancellation();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
